if_module: RTL and testbench

- Instruction-fetch program counter (PC) unit at the front of the single-cycle CPU.
- Each clock it does one of four things: resets the PC, holds it (halt), takes a PC-relative branch with a word-scaled signed offset, or increments it by 1.
- PC output drives the instruction-memory address directly.

---
 rtl/if_pkg.sv | 20 ++
 rtl/if_next_pc.sv | 39 +++
 rtl/if_module.sv | 72 +++++++
 tb/tb_if_module.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared widths, types and branch-offset helper for the instruction-fetch PC unit.
// Consumed by if_next_pc and if_module (optional counters: IF_PERF_CNT_EN).
package if_pkg;

   localparam int PC_W       = 8;
   localparam int TGT_W      = 3;
   localparam int TGT_SHIFT  = 2;
   localparam int PERF_CNT_W = 16;

   typedef logic [PC_W-1:0]  pc_t;
   typedef logic [TGT_W-1:0] tgt_t;

   // Word-scaled signed offset; adding it modulo 2^PC_W gives the branch target.
   function automatic pc_t branch_offset(input tgt_t tgt);
      logic signed [PC_W-1:0] ext;
      ext = {{(PC_W-TGT_W){tgt[TGT_W-1]}}, tgt};
      return pc_t'(ext <<< TGT_SHIFT);
   endfunction

endpackage

// File: rtl/if_next_pc.sv
// Combinational next-PC selection: hold on Halt, else relative branch, else PC+1.
// All arithmetic wraps modulo 2^PC_W.
module if_next_pc
   import if_pkg::*;
#(
   parameter int PC_W      = if_pkg::PC_W,
   parameter int TGT_W     = if_pkg::TGT_W,
   parameter int TGT_SHIFT = if_pkg::TGT_SHIFT
) (
   input  logic [PC_W-1:0]  PC,
   input  logic             Halt,
   input  logic             Branch,
   input  logic [TGT_W-1:0] Target,
   output logic [PC_W-1:0]  PC_next
);

   logic [PC_W-1:0] offset;

   // Default geometry shares the package helper; other sizes use the same math inline.
   generate
      if (PC_W == if_pkg::PC_W && TGT_W == if_pkg::TGT_W && TGT_SHIFT == if_pkg::TGT_SHIFT) begin : g_pkg_off
         assign offset = branch_offset(Target);
      end else begin : g_gen_off
         logic signed [PC_W-1:0] tgt_sext;
         assign tgt_sext = {{(PC_W-TGT_W){Target[TGT_W-1]}}, Target};
         assign offset   = tgt_sext <<< TGT_SHIFT;
      end
   endgenerate

   always_comb begin
      PC_next = PC + PC_W'(1);
      if (Halt) begin
         PC_next = PC;
      end else if (Branch) begin
         PC_next = PC + offset;
      end
   end

endmodule

// File: rtl/if_module.sv
// Instruction-fetch PC register with async Init; next-PC logic lives in if_next_pc.
// Define IF_PERF_CNT_EN to add saturating InstCount/BranchCount outputs.
module if_module
   import if_pkg::*;
#(
   parameter int PC_W      = if_pkg::PC_W,
   parameter int TGT_W     = if_pkg::TGT_W,
   parameter int TGT_SHIFT = if_pkg::TGT_SHIFT
) (
   input  logic             CLK,
   input  logic             Init,
   input  logic             Halt,
   input  logic             Branch,
   input  logic [TGT_W-1:0] Target,
`ifdef IF_PERF_CNT_EN
   output logic [PERF_CNT_W-1:0] InstCount,
   output logic [PERF_CNT_W-1:0] BranchCount,
`endif
   output logic [PC_W-1:0]  PC
);

   logic [PC_W-1:0] pc_q;
   logic [PC_W-1:0] pc_next;

   if_next_pc #(
      .PC_W      (PC_W),
      .TGT_W     (TGT_W),
      .TGT_SHIFT (TGT_SHIFT)
   ) u_next_pc (
      .PC      (pc_q),
      .Halt    (Halt),
      .Branch  (Branch),
      .Target  (Target),
      .PC_next (pc_next)
   );

   always_ff @(posedge CLK or posedge Init) begin
      if (Init) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_next;
      end
   end

   assign PC = pc_q;

`ifdef IF_PERF_CNT_EN
   logic [PERF_CNT_W-1:0] inst_cnt_q;
   logic [PERF_CNT_W-1:0] br_cnt_q;

   function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] c);
      return (&c) ? c : c + PERF_CNT_W'(1);
   endfunction

   // Counters stick at all-ones instead of wrapping.
   always_ff @(posedge CLK or posedge Init) begin
      if (Init) begin
         inst_cnt_q <= '0;
         br_cnt_q   <= '0;
      end else if (!Halt) begin
         inst_cnt_q <= sat_inc(inst_cnt_q);
         if (Branch) begin
            br_cnt_q <= sat_inc(br_cnt_q);
         end
      end
   end

   assign InstCount   = inst_cnt_q;
   assign BranchCount = br_cnt_q;
`endif

endmodule

// File: tb/tb_if_module.sv
// Directed bench for if_module: reset, branches, halt priority, wrap and async Init.
// Counter checks are included when IF_PERF_CNT_EN is defined.
module tb_if_module;

   logic       CLK;
   logic       Init;
   logic       Halt;
   logic       Branch;
   logic [2:0] Target;
   logic [7:0] PC;
`ifdef IF_PERF_CNT_EN
   logic [15:0] InstCount;
   logic [15:0] BranchCount;
`endif

   int n_cmp;
   int n_err;

   if_module dut (
      .CLK         (CLK),
      .Init        (Init),
      .Halt        (Halt),
      .Branch      (Branch),
      .Target      (Target),
`ifdef IF_PERF_CNT_EN
      .InstCount   (InstCount),
      .BranchCount (BranchCount),
`endif
      .PC          (PC)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Init = 1'b1; Halt = 1'b0; Branch = 1'b0; Target = 3'b000;
      #2;
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL reset_async: PC=%0h expected 00", PC); end
      tick();
      Halt = 1'b1; Branch = 1'b1; Target = 3'b011;
      tick();
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL reset_hold: PC=%0h expected 00", PC); end
      Init = 1'b0; Halt = 1'b0; Branch = 1'b0; Target = 3'b000;
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_cmp++;
         if (PC !== 8'(i)) begin n_err++; $display("FAIL reset_incr: PC=%0h expected %0h", PC, i); end
      end
   endtask

   task automatic test_fwd_branch();
      Branch = 1'b1; Target = 3'b001;
      tick();
      n_cmp++;
      if (PC !== 8'h07) begin n_err++; $display("FAIL fwd_branch: PC=%0h expected 07", PC); end
      Branch = 1'b0;
      tick();
      n_cmp++;
      if (PC !== 8'h08) begin n_err++; $display("FAIL fwd_after1: PC=%0h expected 08", PC); end
      tick();
      n_cmp++;
      if (PC !== 8'h09) begin n_err++; $display("FAIL fwd_after2: PC=%0h expected 09", PC); end
   endtask

   task automatic test_bwd_halt();
      Branch = 1'b1; Target = 3'b111;
      tick();
      n_cmp++;
      if (PC !== 8'h05) begin n_err++; $display("FAIL bwd_branch: PC=%0h expected 05", PC); end
      Branch = 1'b0; Halt = 1'b1;
      tick();
      n_cmp++;
      if (PC !== 8'h05) begin n_err++; $display("FAIL halt_hold: PC=%0h expected 05", PC); end
      Halt = 1'b0;
      tick();
      n_cmp++;
      if (PC !== 8'h06) begin n_err++; $display("FAIL halt_resume: PC=%0h expected 06", PC); end
   endtask

   task automatic test_priority();
      Halt = 1'b1; Branch = 1'b1; Target = 3'b001;
      tick();
      n_cmp++;
      if (PC !== 8'h06) begin n_err++; $display("FAIL halt_over_branch: PC=%0h expected 06", PC); end
      Halt = 1'b0; Target = 3'b000;
      tick();
      n_cmp++;
      if (PC !== 8'h06) begin n_err++; $display("FAIL zero_target: PC=%0h expected 06", PC); end
      Branch = 1'b0;
   endtask

   task automatic test_wrap();
      // 6 -> 0xFF in 249 increments
      for (int i = 7; i <= 255; i++) begin
         tick();
         n_cmp++;
         if (PC !== 8'(i)) begin n_err++; $display("FAIL run_up: PC=%0h expected %0h", PC, i); end
      end
      tick();
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL wrap_incr: PC=%0h expected 00", PC); end
      tick(); tick();
      n_cmp++;
      if (PC !== 8'h02) begin n_err++; $display("FAIL pre_neg: PC=%0h expected 02", PC); end
      Branch = 1'b1; Target = 3'b111;
      tick();
      n_cmp++;
      if (PC !== 8'hFE) begin n_err++; $display("FAIL wrap_neg: PC=%0h expected FE", PC); end
      Branch = 1'b0;
      tick(); tick();
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL pre_min: PC=%0h expected 00", PC); end
      Branch = 1'b1; Target = 3'b100;
      tick();
      n_cmp++;
      if (PC !== 8'hF0) begin n_err++; $display("FAIL min_offset: PC=%0h expected F0", PC); end
      Target = 3'b011;
      tick();
      n_cmp++;
      if (PC !== 8'hFC) begin n_err++; $display("FAIL max_offset: PC=%0h expected FC", PC); end
      Branch = 1'b0; Target = 3'b000;
   endtask

   task automatic test_perf_cnt();
`ifdef IF_PERF_CNT_EN
      // 268 edges after Init fell, 2 halted; 6 taken branches
      n_cmp++;
      if (InstCount !== 16'd266) begin n_err++; $display("FAIL inst_count: got %0d expected 266", InstCount); end
      n_cmp++;
      if (BranchCount !== 16'd6) begin n_err++; $display("FAIL branch_count: got %0d expected 6", BranchCount); end
`endif
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 46; i++) tick();
      n_cmp++;
      if (PC !== 8'h2A) begin n_err++; $display("FAIL pre_reset: PC=%0h expected 2A", PC); end
      #2;
      Init = 1'b1;
      #1;
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL async_init: PC=%0h expected 00", PC); end
`ifdef IF_PERF_CNT_EN
      n_cmp++;
      if (InstCount !== 16'd0 || BranchCount !== 16'd0) begin
         n_err++; $display("FAIL cnt_clear: got %0d/%0d expected 0/0", InstCount, BranchCount);
      end
`endif
      Branch = 1'b1; Target = 3'b001;
      tick(); tick();
      n_cmp++;
      if (PC !== 8'h00) begin n_err++; $display("FAIL init_hold: PC=%0h expected 00", PC); end
      #2;
      Init = 1'b0; Branch = 1'b0; Target = 3'b000;
      tick();
      n_cmp++;
      if (PC !== 8'h01) begin n_err++; $display("FAIL post_init: PC=%0h expected 01", PC); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_fwd_branch();
      test_bwd_halt();
      test_priority();
      test_wrap();
      test_perf_cnt();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
